inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- PC/fetch stage of the single-cycle MIPS CPU, directly upstream of the instruction ROM.
- Holds the program counter and drives the 10-bit word address into the ROM. Takes back the 32-bit instruction and presents it to the decoder.
- Computes next-PC for sequential, branch, jump and jr flow. Owns a RUN/HALTED state machine and retired-instruction/cycle counters for the display.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 10, ROM word-address width; rom_addr = pc[ADDR_W+1:2].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and counters' instr count this cycle (RUN only).
- branch_taken  in  1  conditional branch resolved taken this cycle.
- branch_imm  in  16  raw I-type immediate.
- jump  in  1  J/JAL this cycle.
- jump_index  in  26  J-type target field.
- jr  in  1  JR/JALR this cycle.
- jr_target  in  32  register value for jr.
- halt  in  1  syscall-halt decoded this cycle.
- go  in  1  resume pulse from board button (already debounced).
- rom_addr  out  ADDR_W  word address to ROM.
- rom_data  in  32  instruction word from ROM (combinational read).
- instr  out  32  instruction to decoder; 32'h0 (nop) while HALTED.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, for JAL link.
- halted  out  1  1 in HALTED state.
- misaligned  out  1  sticky: a jr_target with bits[1:0] != 0 was taken.
- instr_cnt  out  32  instructions retired.
- cycle_cnt  out  32  clock cycles spent in RUN.

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=RUN, halted=0, misaligned=0, instr_cnt=0, cycle_cnt=0. Outputs are valid immediately after reset.
- rom_addr = pc[ADDR_W+1:2], combinational. PC beyond ROM range wraps modulo 2^ADDR_W words.
- instr = rom_data in RUN, 0 in HALTED. Fetch latency is zero cycles; ROM is asynchronous.
- pc_plus4 = pc + 32'd4, mod 2^32.
- Next-PC in RUN with stall=0, priority jr > jump > branch_taken > sequential:
  - jr: {jr_target[31:2], 2'b00}; set misaligned if jr_target[1:0] != 0.
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch: pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), mod 2^32.
  - otherwise: pc_plus4.
- In RUN with stall=1: pc holds and instr_cnt holds. cycle_cnt still increments. All flow inputs and halt are ignored.
- State machine:
  - RUN -> HALTED when halt=1 and stall=0. On that edge pc <= pc_plus4 (flow inputs ignored) and instr_cnt increments, because the halt instruction retires.
  - HALTED -> RUN on go=1. pc is unchanged, so execution resumes at the instruction after the halt.
  - go in RUN: no effect. halt in HALTED: no effect.
- In HALTED: pc, instr_cnt and cycle_cnt are frozen, and all flow inputs are ignored.
- Counters: instr_cnt += 1 on each RUN cycle with stall=0. cycle_cnt += 1 on each RUN cycle. Both wrap mod 2^32.
- misaligned clears only on reset.
- Reset mid-operation, in either state, returns everything to reset values on assertion, independent of clk.

Test Plan:
- Reset, ROM preloaded with 4 nops, run 4 cycles -> pc 0,4,8,12. rom_addr 0,1,2,3. instr_cnt=4, cycle_cnt=4.
- At pc=0x10, branch_taken=1, imm=16'hFFFC -> next pc=0x04. With imm=16'h0003 -> next pc=0x20.
- At pc=0x3000_0100, jump=1, index=26'h0000040 -> next pc=0x3000_0100. On the same cycle, jr=1 with jr_target=0x0000_0202 -> next pc=0x200 and misaligned=1 (jr wins).
- stall=1 for 3 cycles at pc=0x8 -> pc stays 0x8, instr_cnt unchanged, cycle_cnt +3.
- halt=1 at pc=0x14 -> halted=1, pc=0x18, instr=0, counters frozen for 10 cycles. Then go=1 -> RUN, rom_addr=6.
- Assert rst_n=0 mid-cycle while HALTED with pc=0x40 -> pc=RESET_PC, halted=0 before the next clk edge.

Source files
------------

// File: rtl/inst_fetch.sv
// Fetch stage of the single-cycle MIPS core: owns the PC, next-PC selection,
// the RUN/HALTED state and the retired-instruction / cycle counters.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_imm,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jr,
  input  logic [31:0]       jr_target,
  input  logic              halt,
  input  logic              go,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       instr,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic              misaligned,
  output logic [31:0]       instr_cnt,
  output logic [31:0]       cycle_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] branch_off_s;

  assign pc_plus4_s   = pc_q + 32'd4;
  assign branch_off_s = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_cnt_d  = instr_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    misaligned_d = misaligned_q;
    case (state_q)
      RUN: begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (!stall) begin
          instr_cnt_d = instr_cnt_q + 32'd1;
          // The halt instruction itself retires, so it steps sequentially.
          if (halt) begin
            state_d = HALTED;
            pc_d    = pc_plus4_s;
          end else if (jr) begin
            pc_d = {jr_target[31:2], 2'b00};
            if (jr_target[1:0] != 2'b00) begin
              misaligned_d = 1'b1;
            end else begin
              misaligned_d = misaligned_q;
            end
          end else if (jump) begin
            pc_d = {pc_plus4_s[31:28], jump_index, 2'b00};
          end else if (branch_taken) begin
            pc_d = pc_plus4_s + branch_off_s;
          end else begin
            pc_d = pc_plus4_s;
          end
        end else begin
          instr_cnt_d = instr_cnt_q;
        end
      end
      HALTED: begin
        if (go) begin
          state_d = RUN;
        end else begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      instr_cnt_q  <= 32'd0;
      cycle_cnt_q  <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_cnt_q  <= instr_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      misaligned_q <= misaligned_d;
    end
  end

  // ROM read is asynchronous, so the fetched word is presented the same cycle.
  assign rom_addr   = pc_q[ADDR_W+1:2];
  assign instr      = (state_q == HALTED) ? 32'h0000_0000 : rom_data;
  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_s;
  assign halted     = (state_q == HALTED);
  assign misaligned = misaligned_q;
  assign instr_cnt  = instr_cnt_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a behavioural ROM plus hand-computed
// expectations for sequential, branch, jump, jr, stall, halt/go and reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump, jr, halt, go;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data, instr, pc, pc_plus4, instr_cnt, cycle_cnt;
  logic        halted, misaligned;
  logic [31:0] rom [0:1023];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index), .jr(jr),
    .jr_target(jr_target), .halt(halt), .go(go), .rom_addr(rom_addr),
    .rom_data(rom_data), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .halted(halted), .misaligned(misaligned), .instr_cnt(instr_cnt),
    .cycle_cnt(cycle_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; halt = 1'b0; go = 1'b0;
    branch_imm = 16'h0000; jump_index = 26'h0; jr_target = 32'h0;
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    jr = 1'b1; jr_target = tgt;
    step();
    jr = 1'b0; jr_target = 32'h0;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] ic, input logic [31:0] cc);
    chk({tag, "_icnt"}, instr_cnt, ic);
    chk({tag, "_ccnt"}, cycle_cnt, cc);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = (i < 4) ? 32'h0 : (32'h2400_0000 | i);
    clear_in();
    rst_n = 1'b0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_misal", {31'h0, misaligned}, 32'h0);
    chk_cnt("rst", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch through four nops
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc, 32'(i * 4));
      chk("seq_addr", {22'h0, rom_addr}, 32'(i));
      chk("seq_p4", pc_plus4, 32'(i * 4 + 4));
      step();
    end
    chk_cnt("seq", 32'd4, 32'd4);
    chk("seq_pc4", pc, 32'h10);
    chk("seq_instr", instr, 32'h2400_0004);

    // Branches: backward then forward
    branch_taken = 1'b1; branch_imm = 16'hFFFC;
    step();
    chk("br_back", pc, 32'h4);
    branch_taken = 1'b0;
    jr_to(32'h10);
    chk("jr_al_misal", {31'h0, misaligned}, 32'h0);
    branch_taken = 1'b1; branch_imm = 16'h0003;
    step();
    chk("br_fwd", pc, 32'h20);
    branch_taken = 1'b0; branch_imm = 16'h0;
    chk_cnt("br", 32'd7, 32'd7);

    // Jump keeps upper PC bits; jr beats jump and branch
    jr_to(32'h3000_0100);
    chk("wrap_addr", {22'h0, rom_addr}, 32'h40);
    jump = 1'b1; jump_index = 26'h0000040;
    step();
    chk("jump_pc", pc, 32'h3000_0100);
    chk("jump_misal", {31'h0, misaligned}, 32'h0);
    jr = 1'b1; jr_target = 32'h0000_0202; branch_taken = 1'b1; branch_imm = 16'h0010;
    step();
    chk("jr_prio_pc", pc, 32'h200);
    chk("jr_misal", {31'h0, misaligned}, 32'h1);
    clear_in();

    // Stall holds pc and instr_cnt, ignores flow and halt
    jr_to(32'h8);
    stall = 1'b1; jr = 1'b1; jr_target = 32'h100; halt = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("stall_pc", pc, 32'h8);
    chk("stall_halted", {31'h0, halted}, 32'h0);
    chk_cnt("stall", 32'd11, 32'd14);
    clear_in();
    chk("misal_sticky", {31'h0, misaligned}, 32'h1);

    // Halt retires, then everything freezes until go
    jr_to(32'h14);
    halt = 1'b1; jump = 1'b1; jump_index = 26'h3FF_FFFF;
    step();
    clear_in();
    chk("halt_st", {31'h0, halted}, 32'h1);
    chk("halt_pc", pc, 32'h18);
    chk("halt_instr", instr, 32'h0);
    chk_cnt("halt", 32'd13, 32'd16);
    jr = 1'b1; jr_target = 32'h100; branch_taken = 1'b1; halt = 1'b1;
    for (int i = 0; i < 10; i++) step();
    clear_in();
    chk("frz_pc", pc, 32'h18);
    chk("frz_st", {31'h0, halted}, 32'h1);
    chk_cnt("frz", 32'd13, 32'd16);
    go = 1'b1;
    step();
    go = 1'b0;
    chk("go_st", {31'h0, halted}, 32'h0);
    chk("go_pc", pc, 32'h18);
    chk("go_addr", {22'h0, rom_addr}, 32'h6);
    chk("go_instr", instr, 32'h2400_0006);
    chk_cnt("go", 32'd13, 32'd16);
    step();
    chk("resume_pc", pc, 32'h1C);
    go = 1'b1;
    step();
    go = 1'b0;
    chk("go_run_pc", pc, 32'h20);
    chk("go_run_st", {31'h0, halted}, 32'h0);
    chk_cnt("resume", 32'd15, 32'd18);

    // Asynchronous reset while halted
    jr_to(32'h3C);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("pre_rst_pc", pc, 32'h40);
    chk("pre_rst_st", {31'h0, halted}, 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_st", {31'h0, halted}, 32'h0);
    chk("arst_misal", {31'h0, misaligned}, 32'h0);
    chk_cnt("arst", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_pc", pc, 32'h4);
    chk_cnt("post_rst", 32'd1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
